// File: rtl/wallace_final_cpa_pipe_pkg.sv
// Multiplier-wide constants for the Booth-4/Wallace 16x16 datapath.
// Also holds the product word type shared by the compressor tree and the final adder.
package wallace_final_cpa_pipe_pkg;
  localparam int MULT_W    = 16;
  localparam int PROD_W    = 2 * MULT_W;
  localparam int SPLIT_DEF = MULT_W;

  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/wallace_final_cpa_pipe_cpa.sv
// N-bit ripple/inferred carry-propagate segment with carry in and carry out.
module cpa_segment #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] full;

  assign full        = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign {cout, sum} = full;
endmodule

// File: rtl/wallace_final_cpa_pipe.sv
// Final carry-propagate adder of the multiplier: resolves the sum/carry rows into the
// product over two pipeline stages (low segment, then high segment with the low carry).
module wallace_final_cpa_pipe #(
  parameter int PROD_W = wallace_final_cpa_pipe_pkg::PROD_W,
  parameter int SPLIT  = wallace_final_cpa_pipe_pkg::SPLIT_DEF,
  parameter int TAG_W  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_row_d,
  input  logic [PROD_W-1:0] in_row_c,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int HI_W = PROD_W - SPLIT;

  // vld_pipe_q[1] = S1 holds a pair, vld_pipe_q[2] = S2 holds a product
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic              s1_en, s2_en;

  logic [SPLIT-1:0]  lo_sum;
  logic              lo_cout;
  logic [HI_W-1:0]   hi_sum;
  logic              hi_cout_unused;

  logic [SPLIT-1:0]  lo_sum_q, lo_sum_d;
  logic              lo_cout_q, lo_cout_d;
  logic [HI_W-1:0]   d_hi_q, d_hi_d;
  logic [HI_W-1:0]   c_hi_q, c_hi_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  cpa_segment #(.N(SPLIT)) u_cpa_lo (
    .a    (in_row_d[SPLIT-1:0]),
    .b    (in_row_c[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // MSB carry is dropped so two's-complement products wrap naturally
  cpa_segment #(.N(HI_W)) u_cpa_hi (
    .a    (d_hi_q),
    .b    (c_hi_q),
    .cin  (lo_cout_q),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  always_comb begin
    s2_en      = !vld_pipe_q[2] || out_ready;
    s1_en      = !vld_pipe_q[1] || s2_en;
    vld_pipe_d = vld_pipe_q;
    lo_sum_d   = lo_sum_q;
    lo_cout_d  = lo_cout_q;
    d_hi_d     = d_hi_q;
    c_hi_d     = c_hi_q;
    s1_tag_d   = s1_tag_q;
    prod_d     = prod_q;
    s2_tag_d   = s2_tag_q;

    if (s2_en) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        prod_d   = {hi_sum, lo_sum_q};
        s2_tag_d = s1_tag_q;
      end
    end

    // data only captured on a real pair, so idle-bus garbage never enters the pipe
    if (s1_en) begin
      vld_pipe_d[1] = in_valid;
      if (in_valid) begin
        lo_sum_d  = lo_sum;
        lo_cout_d = lo_cout;
        d_hi_d    = in_row_d[PROD_W-1:SPLIT];
        c_hi_d    = in_row_c[PROD_W-1:SPLIT];
        s1_tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe_q <= '0;
      lo_sum_q   <= '0;
      lo_cout_q  <= 1'b0;
      d_hi_q     <= '0;
      c_hi_q     <= '0;
      s1_tag_q   <= '0;
      prod_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      lo_sum_q   <= lo_sum_d;
      lo_cout_q  <= lo_cout_d;
      d_hi_q     <= d_hi_d;
      c_hi_q     <= c_hi_d;
      s1_tag_q   <= s1_tag_d;
      prod_q     <= prod_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign in_ready  = s1_en && !sys_rst;
  assign out_valid = vld_pipe_q[2];
  assign out_prod  = prod_q;
  assign out_tag   = s2_tag_q;
endmodule

// File: tb/tb_wallace_final_cpa_pipe.sv
// Directed bench for the final CPA: literal latency/value checks plus a queue-based
// product model compared against every emitted output.
module tb_wallace_final_cpa_pipe;
  import wallace_final_cpa_pipe_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in_valid;
  logic       in_ready;
  prod_t      in_row_d;
  prod_t      in_row_c;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  prod_t      out_prod;
  logic [3:0] out_tag;

  int tests   = 0;
  int fails   = 0;
  int out_cnt = 0;

  typedef struct {
    prod_t      p;
    logic [3:0] t;
  } exp_t;
  exp_t model_q[$];

  wallace_final_cpa_pipe #(.PROD_W(PROD_W), .SPLIT(SPLIT_DEF), .TAG_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row_d  (in_row_d),
    .in_row_c  (in_row_c),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Model: every accepted pair yields (D + C) mod 2^32 with its tag, in order;
  // a reset cycle discards everything still in flight.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      model_q.delete();
    end else begin
      if (out_valid) begin
        if (model_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          chk("sb_prod", 64'(out_prod), 64'(model_q[0].p));
          chk("sb_tag", 64'(out_tag), 64'(model_q[0].t));
          if (out_ready) begin
            void'(model_q.pop_front());
            out_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.p = in_row_d + in_row_c;
        e.t = in_tag;
        model_q.push_back(e);
      end
    end
  end

  // Pipe empty, out_ready=1: invisible after the accept edge, visible after the next one.
  task automatic send_one(input prod_t d, input prod_t c, input logic [3:0] t,
                          input prod_t ep, input string nm);
    int n;
    in_valid = 1'b1;
    in_row_d = d;
    in_row_c = c;
    in_tag   = t;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_accept_timeout"}, 64'(n < 20), 64'(1));
    step();
    in_valid = 1'b0;
    in_row_d = $urandom();
    in_row_c = $urandom();
    in_tag   = 4'($urandom());
    chk({nm, "_valid_lat1"}, 64'(out_valid), 64'(0));
    step();
    chk({nm, "_valid_lat2"}, 64'(out_valid), 64'(1));
    chk({nm, "_prod"}, 64'(out_prod), 64'(ep));
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c0;
    logic acc;
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_row_d  = '0;
    in_row_c  = '0;
    in_tag    = '0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_prod", 64'(out_prod), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    sys_rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    send_one(32'h0000_FFFF, 32'h0000_0001, 4'd3, 32'h0001_0000, "carry_split");
    send_one(32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0000, "wrap1");
    send_one(32'h8000_0000, 32'h8000_0000, 4'd9, 32'h0000_0000, "wrap2");
    send_one(32'hFFFF_FFF0, 32'h0000_0001, 4'd12, 32'hFFFF_FFF1, "signed_m3x5");

    // streaming: 8 back-to-back pairs
    c0 = out_cnt;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_row_d = 32'(i);
      in_row_c = 32'(i) << 16;
      in_tag   = 4'(i);
      chk("stream_in_ready", 64'(in_ready), 64'(1));
      step();
      if (i >= 1) chk("stream_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_last_valid", 64'(out_valid), 64'(1));
    chk("stream_last_prod", 64'(out_prod), 64'(32'h0007_0007));
    step();
    chk("stream_drained", 64'(out_valid), 64'(0));
    chk("stream_count", 64'(out_cnt - c0), 64'(8));

    // backpressure: only two pairs fit
    out_ready = 1'b0;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_row_d = 32'h1000 + 32'(p);
      in_row_c = 32'h2_0000 * 32'(p + 1);
      in_tag   = 4'(8 + p);
      acc = in_ready;
      step();
      if (acc) p++;
    end
    chk("bp_accepted", 64'(p), 64'(2));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_out_prod_held", 64'(out_prod), 64'(32'h0002_1000));
    chk("bp_out_tag_held", 64'(out_tag), 64'(8));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c0 = out_cnt;
    repeat (4) step();
    chk("bp_drain_count", 64'(out_cnt - c0), 64'(2));
    chk("bp_model_empty", 64'(model_q.size()), 64'(0));

    // reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_row_d  = 32'h111;
    in_row_c  = 32'h222;
    in_tag    = 4'd1;
    step();
    in_row_d  = 32'h333;
    in_row_c  = 32'h444;
    in_tag    = 4'd2;
    step();
    in_valid = 1'b0;
    chk("full_before_rst", 64'(out_valid), 64'(1));
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    step();
    sys_rst   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after_rst_out_valid", 64'(out_valid), 64'(0));
    chk("after_rst_out_prod", 64'(out_prod), 64'(0));
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    step();
    chk("after_rst_no_stale", 64'(out_valid), 64'(0));
    send_one(32'd5, 32'd7, 4'd6, 32'd12, "fresh_after_rst");
    repeat (3) step();
    chk("final_model_empty", 64'(model_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
